// File: rtl/wb_lsu_master_pkg.sv
// Shared encodings for the Wishbone load/store/tag initiator: bus select
// patterns, request size codes, FSM states and a width helper.
package wb_lsu_master_pkg;

  localparam logic [3:0] WB_SEL_BYTE = 4'b0001;
  localparam logic [3:0] WB_SEL_HALF = 4'b0011;
  localparam logic [3:0] WB_SEL_WORD = 4'b1111;
  localparam logic [3:0] WB_SEL_TAG  = 4'b0101;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_TAG  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_GAP  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Minimum bit count able to hold values 0..n-1 (at least 1).
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

  function automatic logic [3:0] sel_of(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return WB_SEL_BYTE;
      SIZE_HALF: return WB_SEL_HALF;
      SIZE_WORD: return WB_SEL_WORD;
      default:   return WB_SEL_TAG;
    endcase
  endfunction

endpackage

// File: rtl/wb_lsu_master_extend.sv
// Load-data extension: sign/zero extends responder data by access size.
module wb_lsu_extend
  import wb_lsu_master_pkg::*;
#(
  parameter int WB_DATA_WIDTH     = 32,
  parameter int GRANULE_TAG_WIDTH = 4
) (
  input  logic [WB_DATA_WIDTH-1:0] i_data,
  input  logic [1:0]               i_size,
  input  logic                     i_unsigned,
  output logic [WB_DATA_WIDTH-1:0] o_data
);

  logic w_sb, w_sh;
  assign w_sb = ~i_unsigned & i_data[7];
  assign w_sh = ~i_unsigned & i_data[15];

  always_comb begin
    o_data = '0;
    case (i_size)
      SIZE_BYTE: o_data = {{(WB_DATA_WIDTH-8){w_sb}}, i_data[7:0]};
      SIZE_HALF: o_data = {{(WB_DATA_WIDTH-16){w_sh}}, i_data[15:0]};
      SIZE_WORD: o_data = i_data;
      default:   o_data = {{(WB_DATA_WIDTH-GRANULE_TAG_WIDTH){1'b0}},
                           i_data[GRANULE_TAG_WIDTH-1:0]};
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone initiator for single load/store/tag requests to the tagged RAM.
// Optional bus timeout is enabled by defining WB_LSU_TIMEOUT_EN.
module wb_lsu_master
  import wb_lsu_master_pkg::*;
#(
  parameter int WB_DATA_WIDTH     = 32,
  parameter int WB_ADDR_WIDTH     = 32,
  parameter int GRANULE_TAG_WIDTH = 4,
  parameter int GAP_CYCLES        = 2,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [WB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] req_wdata_i,
  input  logic                     req_we_i,
  input  logic [1:0]               req_size_i,
  input  logic                     req_unsigned_i,
  output logic                     rsp_valid_o,
  output logic [WB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  output logic [3:0]               wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic                     wb_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i
);

  localparam int GAP_W = log2_ceil(GAP_CYCLES);

  if (WB_DATA_WIDTH != 32 || GAP_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("wb_lsu_master: unsupported parameter set");
  end

  state_t                   r_state;
  logic [WB_ADDR_WIDTH-1:0] r_addr;
  logic [WB_DATA_WIDTH-1:0] r_wdata;
  logic [3:0]               r_sel;
  logic                     r_we;
  logic                     r_cyc;
  logic [1:0]               r_size;
  logic                     r_uns;
  logic                     r_rsp_valid;
  logic                     r_rsp_err;
  logic [WB_DATA_WIDTH-1:0] r_rdata;
  logic [GAP_W-1:0]         r_gap;

  logic                     w_misalign;
  logic [WB_DATA_WIDTH-1:0] w_wdata;
  logic [WB_DATA_WIDTH-1:0] w_ext;

  assign w_misalign = ((req_size_i == SIZE_HALF) && req_addr_i[0]) ||
                      ((req_size_i == SIZE_WORD) && (req_addr_i[1:0] != 2'b00));
  // Sub-word data stays in the low lanes; the responder places it.
  assign w_wdata = (req_size_i == SIZE_TAG) ?
                   {{(WB_DATA_WIDTH-GRANULE_TAG_WIDTH){1'b0}}, req_wdata_i[GRANULE_TAG_WIDTH-1:0]} :
                   req_wdata_i;

  wb_lsu_extend #(
    .WB_DATA_WIDTH     (WB_DATA_WIDTH),
    .GRANULE_TAG_WIDTH (GRANULE_TAG_WIDTH)
  ) u_extend (
    .i_data     (wb_data_i),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_ext)
  );

`ifdef WB_LSU_TIMEOUT_EN
  localparam int TMO_W = log2_ceil(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] r_tmo;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_cyc       <= 1'b0;
      r_size      <= SIZE_BYTE;
      r_uns       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rdata     <= '0;
      r_gap       <= '0;
`ifdef WB_LSU_TIMEOUT_EN
      r_tmo       <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: if (req_valid_i) begin
          r_size <= req_size_i;
          r_uns  <= req_unsigned_i;
          if (w_misalign) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rdata     <= '0;
            r_state     <= ST_ERR;
          end else begin
            r_addr  <= req_addr_i;
            r_wdata <= w_wdata;
            r_sel   <= sel_of(req_size_i);
            r_we    <= req_we_i;
            r_cyc   <= 1'b1;
            r_state <= ST_BUS;
`ifdef WB_LSU_TIMEOUT_EN
            r_tmo   <= '0;
`endif
          end
        end
        ST_BUS: begin
          if (wb_ack_i) begin
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rdata     <= r_we ? '0 : w_ext;
            r_gap       <= GAP_W'(GAP_CYCLES - 1);
            r_state     <= ST_GAP;
          end
`ifdef WB_LSU_TIMEOUT_EN
          else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rdata     <= '0;
            r_gap       <= GAP_W'(GAP_CYCLES - 1);
            r_state     <= ST_GAP;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
`endif
        end
        // Address/sel/data stay put so the responder's post-ack work sees them.
        ST_GAP: begin
          if (r_gap == '0) r_state <= ST_IDLE;
          else             r_gap   <= r_gap - 1'b1;
        end
        ST_ERR: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (r_state == ST_IDLE) && !wb_rst_i;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_rdata_o = r_rdata;
  assign wb_addr_o   = r_addr;
  assign wb_data_o   = r_wdata;
  assign wb_sel_o    = r_sel;
  assign wb_we_o     = r_we;
  assign wb_cyc_o    = r_cyc;
  assign wb_stb_o    = r_cyc;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed, table-driven bench for wb_lsu_master (default build, GAP_CYCLES=2).
module tb_wb_lsu_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_uns;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] wb_addr, wb_dout, wb_din;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb, wb_ack;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_lsu_master dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_uns),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .wb_addr_o      (wb_addr),
    .wb_data_o      (wb_dout),
    .wb_sel_o       (wb_sel),
    .wb_we_o        (wb_we),
    .wb_cyc_o       (wb_cyc),
    .wb_stb_o       (wb_stb),
    .wb_ack_i       (wb_ack),
    .wb_data_i      (wb_din)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ackd;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  sel;
    logic [31:0] bwd;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input vec_t v);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_size  = v.size;
    req_uns   = v.uns;
    req_addr  = v.addr;
    req_wdata = v.wdata;
  endtask

  task automatic do_vec(input vec_t v);
    drive_req(v);
    tick();
    req_valid = 1'b0;
    check("ready_low_after_accept", {31'd0, req_ready}, 32'd0);
    if (v.err) begin
      check("err_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("err_rsp_err", {31'd0, rsp_err}, 32'd1);
      check("err_rdata", rsp_rdata, 32'd0);
      check("err_no_cyc", {31'd0, wb_cyc}, 32'd0);
      tick();
      check("err_valid_one_cycle", {31'd0, rsp_valid}, 32'd0);
      check("err_ready_back", {31'd0, req_ready}, 32'd1);
    end else begin
      check("bus_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd3);
      check("bus_sel", {28'd0, wb_sel}, {28'd0, v.sel});
      check("bus_we", {31'd0, wb_we}, {31'd0, v.we});
      check("bus_addr", wb_addr, v.addr);
      check("bus_wdata", wb_dout, v.bwd);
      tick();
      check("bus_cyc_wait", {31'd0, wb_cyc}, 32'd1);
      @(negedge clk);
      wb_ack = 1'b1;
      wb_din = v.ackd;
      tick();
      wb_ack = 1'b0;
      wb_din = 32'hBAD0_BAD0;
      check("gap1_cyc_low", {30'd0, wb_cyc, wb_stb}, 32'd0);
      check("gap1_we_low", {31'd0, wb_we}, 32'd0);
      check("gap1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("gap1_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("gap1_rdata", rsp_rdata, v.rdata);
      check("gap1_addr_held", wb_addr, v.addr);
      check("gap1_ready_low", {31'd0, req_ready}, 32'd0);
      tick();
      check("gap2_rsp_valid_low", {31'd0, rsp_valid}, 32'd0);
      check("gap2_addr_held", wb_addr, v.addr);
      check("gap2_sel_held", {28'd0, wb_sel}, {28'd0, v.sel});
      check("gap2_wdata_held", wb_dout, v.bwd);
      check("gap2_ready_low", {31'd0, req_ready}, 32'd0);
      check("gap2_rdata_held", rsp_rdata, v.rdata);
      tick();
      check("idle_ready", {31'd0, req_ready}, 32'd1);
      check("idle_no_cyc", {31'd0, wb_cyc}, 32'd0);
    end
  endtask

  initial begin
    int n;
    vec_t lv;
    //          we    size   uns   addr          wdata         ackd          err   rdata         sel   bus wdata
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        1'b0, 32'h0,        4'hF, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        32'h0000_0080, 1'b0, 32'hFFFF_FF80, 4'h1, 32'h0};
    vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,        32'h0000_0080, 1'b0, 32'h0000_0080, 4'h1, 32'h0};
    vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'h0,        32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
    vecs[4]  = '{1'b1, 2'b11, 1'b0, 32'h2000_0040, 32'hFFFF_FFA5, 32'h0,        1'b0, 32'h0,        4'h5, 32'h0000_0005};
    vecs[5]  = '{1'b0, 2'b11, 1'b0, 32'h2000_0040, 32'h0,        32'h0000_0035, 1'b0, 32'h0000_0005, 4'h5, 32'h0};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0,        32'h0000_8001, 1'b0, 32'hFFFF_8001, 4'h3, 32'h0};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,        32'h0,        1'b1, 32'h0,        4'h0, 32'h0};
    vecs[8]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0,        32'hABCD_8001, 1'b0, 32'h0000_8001, 4'h3, 32'h0};
    vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,        32'h1234_5678, 1'b0, 32'h1234_5678, 4'hF, 32'h0};
    vecs[10] = '{1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h1234_56AB, 32'h0,        1'b0, 32'h0,        4'h1, 32'h1234_56AB};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_uns = 1'b0;
    req_addr = '0; req_wdata = '0; wb_ack = 1'b0; wb_din = '0;
    tick(); tick(); tick();
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_ctl", {26'd0, wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err, 1'b0}, 32'd0);
    check("rst_addr", wb_addr, 32'd0);
    check("rst_wdata", wb_dout, 32'd0);
    check("rst_sel", {28'd0, wb_sel}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);
    // Stray ack while idle must not produce anything.
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    check("idle_ack_ignored", {30'd0, rsp_valid, wb_cyc}, 32'd0);

    for (int i = 0; i < 11; i++) do_vec(vecs[i]);

    // Back-to-back loads with valid held high.
    lv = vecs[9];
    drive_req(lv);
    tick();
    check("b2b_first_cyc", {31'd0, wb_cyc}, 32'd1);
    @(negedge clk);
    wb_ack = 1'b1;
    wb_din = 32'h0000_00AA;
    tick();
    wb_ack = 1'b0;
    check("b2b_first_rdata", rsp_rdata, 32'h0000_00AA);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n++;
      if (wb_cyc) break;
    end
    req_valid = 1'b0;
    check("b2b_spacing", n, 32'd3);
    @(negedge clk);
    wb_ack = 1'b1;
    wb_din = 32'h0000_0055;
    tick();
    wb_ack = 1'b0;
    check("b2b_second_rsp", {31'd0, rsp_valid}, 32'd1);
    check("b2b_second_rdata", rsp_rdata, 32'h0000_0055);
    tick(); tick();
    check("b2b_idle", {31'd0, req_ready}, 32'd1);

    // Reset while the bus cycle is outstanding.
    drive_req(vecs[1]);
    tick();
    req_valid = 1'b0;
    check("mid_rst_cyc_before", {31'd0, wb_cyc}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("mid_rst_cyc_drop", {30'd0, wb_cyc, wb_stb}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rsp_valid) n++;
    end
    check("mid_rst_no_rsp", n, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
